color_fade_sequencer: RTL
=========================

COLOR_FADE_SEQUENCER -- requirements
Module: color_fade_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_COLORS, default 5: number of palette entries sequenced, addresses 0..NUM_COLORS-1.
REQ-002 The block SHALL have parameter STEP_LOG2, default 4: fade steps per transition = 2^STEP_LOG2.
REQ-003 The block SHALL have parameter FRAME_CYCLES, default 1000: clock cycles between successive fade steps.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: level; 1 runs the sequence, 0 pauses at the next IDLE entry.
REQ-007 The block SHALL have port color_addr, output, 3 bits: palette address to the combinational colour memory.
REQ-008 The block SHALL have port color_data, input, 24 bits: palette RGB read data, [23:16]=R, [15:8]=G, [7:0]=B, valid in the same cycle as color_addr.
REQ-009 The block SHALL have port pixel_data, output, 24 bits: blended RGB, same field order as color_data.
REQ-010 The block SHALL have port pixel_valid, output, 1 bit: pixel_data is offered to the LED driver.
REQ-011 The block SHALL have port pixel_ready, input, 1 bit: the driver accepts pixel_data when pixel_valid=1 and pixel_ready=1 on a rising edge.
REQ-012 The block SHALL have port step_idx, output, STEP_LOG2 bits: current fade step.
REQ-013 The block SHALL have port cur_idx, output, 3 bits: current source palette index.

Function
REQ-014 FSM states SHALL be IDLE, LOAD_CUR, LOAD_NXT, BLEND, SEND, WAIT.
REQ-015 In IDLE with enable=1, the FSM SHALL go to LOAD_CUR; with enable=0 it SHALL stay in IDLE.
REQ-016 LOAD_CUR SHALL drive color_addr=cur_idx, register color_data into cur_color, and go to LOAD_NXT (1 cycle).
REQ-017 LOAD_NXT SHALL drive color_addr=nxt_idx, register color_data into nxt_color, and go to BLEND (1 cycle); nxt_idx = cur_idx+1, wrapping to 0 when cur_idx = NUM_COLORS-1.
REQ-018 color_addr SHALL hold its last value in all states other than LOAD_CUR and LOAD_NXT.
REQ-019 BLEND SHALL compute, per 8-bit channel, out = (cur*(S-k) + nxt*k) >> STEP_LOG2, where S = 2^STEP_LOG2 and k = step_idx.
REQ-020 The BLEND products SHALL use at least 8+STEP_LOG2+1 bits, truncate rather than round, and never overflow.
REQ-021 BLEND SHALL register the result into pixel_data and go to SEND (1 cycle).
REQ-022 In SEND, pixel_valid SHALL be 1 and pixel_data SHALL be stable until the handshake completes.
REQ-023 On the SEND handshake, the FSM SHALL go to WAIT and pixel_valid SHALL fall on the next cycle.
REQ-024 In SEND with pixel_ready=0, the FSM SHALL stall indefinitely; the frame counter SHALL NOT run.
REQ-025 WAIT SHALL count FRAME_CYCLES-1 cycles from 0.
REQ-026 At the end of the WAIT count with step_idx < S-1, step_idx SHALL increment and the FSM SHALL go to BLEND; the palette SHALL NOT be reloaded.
REQ-027 At the end of the WAIT count with step_idx = S-1, step_idx SHALL become 0 and cur_idx SHALL become nxt_idx (wrapping).
REQ-028 After the update in REQ-027, the FSM SHALL go to LOAD_CUR if enable=1, else to IDLE.
REQ-029 enable falling mid-transition SHALL NOT abort the transition; the pause takes effect only at the transition boundary (REQ-028).
REQ-030 Step 0 of each transition SHALL output exactly cur_color; the final step (k = S-1) SHALL output cur + (nxt-cur)*(S-1)/S, truncated per channel.
REQ-031 The full sequence SHALL be 0->1->2->3->4->0 for the default parameters.
REQ-032 The latency from IDLE with enable=1 to the first pixel_valid SHALL be 4 cycles: LOAD_CUR, LOAD_NXT, BLEND, then SEND.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state=IDLE, cur_idx=0, step_idx=0, the frame counter to 0, color_addr=0, pixel_data=24'h000000, pixel_valid=0, cur_color=0 and nxt_color=0.
REQ-034 Reset asserted mid-SEND SHALL drop pixel_valid immediately without completing the handshake.
REQ-035 After rst_n deasserts, the sequence SHALL restart from index 0, step 0.

Verification
REQ-036 Reset then enable=1 with pixel_ready=1 and a memory model {FFFFFF, 0000FF, 000000, FF0000, FFFF00} -> first pixel_valid on the 4th cycle after IDLE with pixel_data=FFFFFF, and color_addr reads 0 then 1.
REQ-037 Step sweep 0->1 with STEP_LOG2=4 -> pixel_data R/G go FF, EF, DF ... 0F; B stays FF; step_idx goes 0..15; the next transition starts with pixel_data=0000FF.
REQ-038 Wrap: run to cur_idx=4 -> nxt address=0, and blends go FFFF00 toward FFFFFF (B 00, 0F, 1F ...); then cur_idx=0.
REQ-039 Backpressure: hold pixel_ready=0 for 50 cycles in SEND -> pixel_valid=1 and pixel_data constant throughout, step_idx unchanged, the frame counter frozen.
REQ-040 Pause: drop enable at step 7 -> the steps continue to 15, then the FSM enters IDLE with cur_idx advanced; re-enabling resumes at the new index, step 0.
REQ-041 Async reset pulse mid-WAIT and mid-SEND -> all outputs are zero within the same cycle, and the restart sequence matches REQ-036.

Source files
------------

// File: rtl/color_fade_sequencer.sv
// Palette fade sequencer: walks a palette, blending each entry into the next over
// 2^STEP_LOG2 frames and offering each blended pixel to an LED driver via valid/ready.
module color_fade_sequencer #(
   parameter int unsigned NUM_COLORS   = 5,
   parameter int unsigned STEP_LOG2    = 4,
   parameter int unsigned FRAME_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   output logic [2:0]           color_addr,
   input  logic [23:0]          color_data,
   output logic [23:0]          pixel_data,
   output logic                 pixel_valid,
   input  logic                 pixel_ready,
   output logic [STEP_LOG2-1:0] step_idx,
   output logic [2:0]           cur_idx
);

   localparam int unsigned IDX_W    = 3;
   localparam int unsigned CH_W     = 8;
   localparam int unsigned PROD_W   = CH_W + STEP_LOG2 + 1;
   localparam int unsigned WAIT_LEN = (FRAME_CYCLES > 2) ? FRAME_CYCLES - 1 : 1;
   localparam int unsigned CNT_W    = (WAIT_LEN > 1) ? $clog2(WAIT_LEN) : 1;

   localparam logic [STEP_LOG2-1:0] STEP_LAST = '1;
   localparam logic [STEP_LOG2:0]   STEP_SIZE = {1'b1, {STEP_LOG2{1'b0}}};
   localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_COLORS - 1);
   localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(WAIT_LEN - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD_CUR = 3'd1;
   localparam logic [2:0] S_LOAD_NXT = 3'd2;
   localparam logic [2:0] S_BLEND    = 3'd3;
   localparam logic [2:0] S_SEND     = 3'd4;
   localparam logic [2:0] S_WAIT     = 3'd5;

   logic [2:0]           state_q,       state_d;
   logic [IDX_W-1:0]     cur_idx_q,     cur_idx_d;
   logic [STEP_LOG2-1:0] step_idx_q,    step_idx_d;
   logic [CNT_W-1:0]     frame_cnt_q,   frame_cnt_d;
   logic [IDX_W-1:0]     color_addr_q,  color_addr_d;
   logic [23:0]          cur_color_q,   cur_color_d;
   logic [23:0]          nxt_color_q,   nxt_color_d;
   logic [23:0]          pixel_data_q,  pixel_data_d;
   logic                 pixel_valid_q, pixel_valid_d;

   logic [IDX_W-1:0]     nxt_idx;
   logic [23:0]          blend_px;

   // Weighted average of one channel; products are wide enough that S*255 never wraps.
   function automatic logic [CH_W-1:0] blend_ch(input logic [CH_W-1:0]      a,
                                                input logic [CH_W-1:0]      b,
                                                input logic [STEP_LOG2-1:0] k);
      logic [STEP_LOG2:0] w_cur;
      logic [PROD_W-1:0]  p_cur;
      logic [PROD_W-1:0]  p_nxt;
      logic [PROD_W-1:0]  sum;
      w_cur = STEP_SIZE - {1'b0, k};
      p_cur = PROD_W'(a) * PROD_W'(w_cur);
      p_nxt = PROD_W'(b) * PROD_W'(k);
      sum   = p_cur + p_nxt;
      return CH_W'(sum >> STEP_LOG2);
   endfunction

   always_comb begin
      nxt_idx  = (cur_idx_q == IDX_LAST) ? '0 : cur_idx_q + IDX_W'(1);
      blend_px = {blend_ch(cur_color_q[23:16], nxt_color_q[23:16], step_idx_q),
                  blend_ch(cur_color_q[15:8],  nxt_color_q[15:8],  step_idx_q),
                  blend_ch(cur_color_q[7:0],   nxt_color_q[7:0],   step_idx_q)};
   end

   // Next-state and datapath updates; color_addr is set one edge ahead so it is
   // already valid during the LOAD_CUR/LOAD_NXT cycle that captures color_data.
   always_comb begin
      state_d       = state_q;
      cur_idx_d     = cur_idx_q;
      step_idx_d    = step_idx_q;
      frame_cnt_d   = frame_cnt_q;
      color_addr_d  = color_addr_q;
      cur_color_d   = cur_color_q;
      nxt_color_d   = nxt_color_q;
      pixel_data_d  = pixel_data_q;
      pixel_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d      = S_LOAD_CUR;
               color_addr_d = cur_idx_q;
            end
         end
         S_LOAD_CUR: begin
            cur_color_d  = color_data;
            color_addr_d = nxt_idx;
            state_d      = S_LOAD_NXT;
         end
         S_LOAD_NXT: begin
            nxt_color_d = color_data;
            state_d     = S_BLEND;
         end
         S_BLEND: begin
            pixel_data_d = blend_px;
            state_d      = S_SEND;
         end
         S_SEND: begin
            if (pixel_ready) begin
               frame_cnt_d = '0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (frame_cnt_q == CNT_LAST) begin
               frame_cnt_d = '0;
               if (step_idx_q != STEP_LAST) begin
                  step_idx_d = step_idx_q + STEP_LOG2'(1);
                  state_d    = S_BLEND;
               end else begin
                  step_idx_d = '0;
                  cur_idx_d  = nxt_idx;
                  if (enable) begin
                     color_addr_d = nxt_idx;
                     state_d      = S_LOAD_CUR;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end else begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      pixel_valid_d = (state_d == S_SEND);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cur_idx_q     <= '0;
         step_idx_q    <= '0;
         frame_cnt_q   <= '0;
         color_addr_q  <= '0;
         cur_color_q   <= '0;
         nxt_color_q   <= '0;
         pixel_data_q  <= '0;
         pixel_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_idx_q     <= cur_idx_d;
         step_idx_q    <= step_idx_d;
         frame_cnt_q   <= frame_cnt_d;
         color_addr_q  <= color_addr_d;
         cur_color_q   <= cur_color_d;
         nxt_color_q   <= nxt_color_d;
         pixel_data_q  <= pixel_data_d;
         pixel_valid_q <= pixel_valid_d;
      end
   end

   assign color_addr  = color_addr_q;
   assign pixel_data  = pixel_data_q;
   assign pixel_valid = pixel_valid_q;
   assign step_idx    = step_idx_q;
   assign cur_idx     = cur_idx_q;

endmodule
